bram_delay_line: RTL and testbench

- Clock-enable-gated delay line of DATA_WIDTH-bit samples, built on inferred block RAM with a circular read/write pointer.
- Output equals the sample accepted exactly DELAY enabled cycles earlier; cycles with ce=0 do not advance it.
- Sits in the streaming image path as a line buffer: with DELAY = image width and ce = pixel data-enable, it yields the same-column pixel of the previous row, ignoring blanking porches.

---
 rtl/bram_delay_line_pkg.sv | 20 ++
 rtl/bram_delay_line_sdp_ram.sv | 29 ++
 rtl/bram_delay_line.sv | 67 ++++++
 tb/tb_bram_delay_line.sv | 139 +++++++++++++
 4 files changed

// File: rtl/bram_delay_line_pkg.sv
// Shared helpers for the block-RAM delay line: ceiling log2, delay limit and pointer width.
package delay_pkg;

    localparam int MAX_DELAY = 4096;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Pointer addresses a memory of delay-1 entries; keep at least one bit.
    function automatic int PTR_W(input int delay);
        int w;
        w = clog2(delay - 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/bram_delay_line_sdp_ram.sv
// Simple dual-port synchronous RAM, read-before-write, with a synchronously clearable read register.
module sdp_ram #(
    parameter int DATA_WIDTH = 12,
    parameter int DEPTH      = 99,
    parameter int ADDR_W     = 7
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic                  rd_clr,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Output register clear maps onto the BRAM output-latch reset.
    always_ff @(posedge clk) begin
        if (rd_clr)  rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/bram_delay_line.sv
// ce-gated delay line of DELAY samples on a circular-pointer block RAM.
// Define BRAM_DELAY_LINE_ZERO_FILL_EN to hold data_out at 0 until the line has filled.
module bram_delay_line
    import delay_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int DELAY      = 100
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out
);

    generate
        if (DELAY == 1) begin : g_reg
            always_ff @(posedge clk) begin
                if (rst)     data_out <= '0;
                else if (ce) data_out <= data_in;
            end
        end else begin : g_ram
            localparam int DEPTH = DELAY - 1;
            localparam int AW    = PTR_W(DELAY);
            localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

            logic [AW-1:0] ptr;
            logic          rd_clr;

            always_ff @(posedge clk) begin
                if (rst)     ptr <= '0;
                else if (ce) ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
            end

`ifdef BRAM_DELAY_LINE_ZERO_FILL_EN
            localparam int CW = clog2(DELAY + 1);
            logic [CW-1:0] fill_cnt;

            always_ff @(posedge clk) begin
                if (rst)                                fill_cnt <= '0;
                else if (ce && fill_cnt != CW'(DELAY))  fill_cnt <= fill_cnt + 1'b1;
            end

            // Clearing the read register until the DELAY-th accepted edge hides stale memory.
            assign rd_clr = rst | (ce & (fill_cnt < CW'(DELAY - 1)));
`else
            assign rd_clr = rst;
`endif

            sdp_ram #(
                .DATA_WIDTH (DATA_WIDTH),
                .DEPTH      (DEPTH),
                .ADDR_W     (AW)
            ) u_ram (
                .clk    (clk),
                .we     (ce & ~rst),
                .waddr  (ptr),
                .wdata  (data_in),
                .re     (ce),
                .rd_clr (rd_clr),
                .raddr  (ptr),
                .rdata  (data_out)
            );
        end
    endgenerate

endmodule

// File: tb/tb_bram_delay_line.sv
// Bench for bram_delay_line at DELAY=100, 2 and 1 driven from one shared stimulus stream.
module tb_bram_delay_line;

`ifdef BRAM_DELAY_LINE_ZERO_FILL_EN
    localparam bit ZF = 1'b1;
`else
    localparam bit ZF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce  = 1'b0;
    logic [11:0] din = '0;
    logic [11:0] out100, out2, out1;

    int checks   = 0;
    int failures = 0;

    logic [11:0] q100[$], q2[$], q1[$];
    logic [11:0] e100 = '0, e2 = '0, e1 = '0;
    bit          k100 = 1'b0, k2 = 1'b0, k1 = 1'b0;

    typedef struct {
        logic        rst;
        logic        ce;
        logic [11:0] din;
        logic [11:0] exp2;
        logic [11:0] exp1;
    } vec_t;

    vec_t tbl[8];

    always #5 clk = ~clk;

    bram_delay_line #(.DATA_WIDTH(12), .DELAY(100)) dut100 (
        .clk(clk), .rst(rst), .ce(ce), .data_in(din), .data_out(out100));
    bram_delay_line #(.DATA_WIDTH(12), .DELAY(2)) dut2 (
        .clk(clk), .rst(rst), .ce(ce), .data_in(din), .data_out(out2));
    bram_delay_line #(.DATA_WIDTH(12), .DELAY(1)) dut1 (
        .clk(clk), .rst(rst), .ce(ce), .data_in(din), .data_out(out1));

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle, update the reference queues on the edge, compare 1ns later.
    task automatic clock_step(input logic r, input logic c, input logic [11:0] d);
        rst = r;
        ce  = c;
        din = d;
        @(posedge clk);
        if (r) begin
            q100.delete(); q2.delete(); q1.delete();
            e100 = '0; e2 = '0; e1 = '0;
            k100 = 1'b1; k2 = 1'b1; k1 = 1'b1;
        end else if (c) begin
            q100.push_back(d);
            if (q100.size() == 100) begin e100 = q100.pop_front(); k100 = 1'b1; end
            else begin e100 = '0; k100 = ZF; end
            q2.push_back(d);
            if (q2.size() == 2) begin e2 = q2.pop_front(); k2 = 1'b1; end
            else begin e2 = '0; k2 = ZF; end
            q1.push_back(d);
            if (q1.size() == 1) begin e1 = q1.pop_front(); k1 = 1'b1; end
            else begin e1 = '0; k1 = ZF; end
        end
        #1;
        if (k100) check("sb_d100", out100, e100);
        if (k2)   check("sb_d2", out2, e2);
        if (k1)   check("sb_d1", out1, e1);
    endtask

    initial begin
        logic [11:0] held;

        tbl[0] = '{1'b0, 1'b1, 12'hAAA, 12'h123, 12'hAAA};
        tbl[1] = '{1'b0, 1'b1, 12'h555, 12'hAAA, 12'h555};
        tbl[2] = '{1'b0, 1'b1, 12'hAAA, 12'h555, 12'hAAA};
        tbl[3] = '{1'b0, 1'b0, 12'hFFF, 12'h555, 12'hAAA};
        tbl[4] = '{1'b0, 1'b1, 12'h555, 12'hAAA, 12'h555};
        tbl[5] = '{1'b1, 1'b1, 12'h777, 12'h000, 12'h000};
        tbl[6] = '{1'b0, 1'b1, 12'hAAA, (ZF ? 12'h000 : 12'h555), 12'hAAA};
        tbl[7] = '{1'b0, 1'b1, 12'h555, 12'hAAA, 12'h555};

        // Reset state
        clock_step(1'b1, 1'b0, 12'h0);
        check("reset_d100", out100, 12'h000);
        clock_step(1'b1, 1'b0, 12'h0);

        // Continuous ce=1, incrementing data
        for (int i = 0; i < 250; i++) clock_step(1'b0, 1'b1, 12'(12'h101 + i));

        // Hold for 37 cycles with random data, then continue the same sequence
        held = out100;
        for (int i = 0; i < 37; i++) begin
            clock_step(1'b0, 1'b0, 12'($urandom_range(0, 4095)));
            check("hold_d100", out100, held);
        end
        for (int i = 250; i < 400; i++) clock_step(1'b0, 1'b1, 12'(12'h101 + i));

        // Rows of 100 separated by 10-cycle porches of garbage
        clock_step(1'b1, 1'b0, 12'h0);
        for (int n = 1; n <= 4; n++) begin
            for (int c = 0; c < 100; c++) begin
                if (n >= 2) check("row_col", out100, 12'((n - 1) * 256 + 1 + c));
                clock_step(1'b0, 1'b1, 12'(n * 256 + 1 + c));
            end
            for (int p = 0; p < 10; p++) clock_step(1'b0, 1'b0, 12'($urandom_range(0, 4095)));
        end

        // Reset mid-row after 50 samples
        clock_step(1'b1, 1'b0, 12'h0);
        for (int i = 0; i < 50; i++) clock_step(1'b0, 1'b1, 12'(12'h500 + i));
        clock_step(1'b1, 1'b0, 12'h0);
        check("rst_mid_zero", out100, 12'h000);
        for (int i = 0; i < 100; i++) begin
            clock_step(1'b0, 1'b1, 12'(12'h600 + i));
            if (i == 99)  check("rst_mid_first", out100, 12'h600);
            else if (ZF)  check("rst_mid_fill", out100, 12'h000);
        end

        // DELAY=2 / DELAY=1 alternating pattern, hold, and rst+ce together
        clock_step(1'b1, 1'b0, 12'h0);
        clock_step(1'b0, 1'b1, 12'h123);
        for (int i = 0; i < 8; i++) begin
            clock_step(tbl[i].rst, tbl[i].ce, tbl[i].din);
            check("tbl_d2", out2, tbl[i].exp2);
            check("tbl_d1", out1, tbl[i].exp1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
